// File: rtl/multi_key_debounce.sv
// Multi-channel key debouncer: 2-FF synchronisers, a shared sample tick, and per-key integrators
// that emit registered level, press, release and long-press pulses.
module multi_key_debounce #(
  parameter int unsigned NUM_KEYS      = 4,
  parameter int unsigned TICK_DIV      = 25000,
  parameter int unsigned STABLE_CNT    = 4,
  parameter int unsigned LONG_TICKS    = 500,
  parameter bit          IN_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int unsigned TickW = $clog2(TICK_DIV);
  localparam int unsigned CntW  = $clog2(STABLE_CNT + 1);
  localparam int unsigned HoldW = (LONG_TICKS > 0) ? $clog2(LONG_TICKS + 1) : 1;

  localparam logic [TickW-1:0]    TickLast = TickW'(TICK_DIV - 1);
  localparam logic [CntW-1:0]     CntLast  = CntW'(STABLE_CNT - 1);
  localparam logic [HoldW-1:0]    HoldMax  = HoldW'(LONG_TICKS);
  localparam logic [HoldW-1:0]    HoldFire = HoldW'(LONG_TICKS - 1);
  localparam logic [NUM_KEYS-1:0] IdleLvl  = {NUM_KEYS{IN_ACTIVE_LOW}};

  logic [NUM_KEYS-1:0] sync1_q, sync2_q, pressed;
  logic [TickW-1:0]    tick_cnt_q;
  logic                tick;

  logic [CntW-1:0]     cnt_d  [NUM_KEYS];
  logic [CntW-1:0]     cnt_q  [NUM_KEYS];
  logic [HoldW-1:0]    hold_d [NUM_KEYS];
  logic [HoldW-1:0]    hold_q [NUM_KEYS];
  logic [NUM_KEYS-1:0] state_d, press_d, release_d, long_d;

  // Synchronisers idle at the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= IdleLvl;
      sync2_q <= IdleLvl;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = IN_ACTIVE_LOW ? ~sync2_q : sync2_q;
  assign tick    = (tick_cnt_q == TickLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = key_state;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k]  = cnt_q[k];
      hold_d[k] = hold_q[k];
      if (tick) begin
        if (pressed[k] == key_state[k]) begin
          cnt_d[k] = '0;
        end else if (cnt_q[k] == CntLast) begin
          cnt_d[k]     = '0;
          state_d[k]   = pressed[k];
          press_d[k]   = pressed[k];
          release_d[k] = ~pressed[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
      // Hold counter saturates at LONG_TICKS so long-press fires once per hold.
      if (!key_state[k]) begin
        hold_d[k] = '0;
      end else if (tick && (hold_q[k] != HoldMax)) begin
        hold_d[k] = hold_q[k] + 1'b1;
        long_d[k] = (LONG_TICKS != 0) && (hold_q[k] == HoldFire);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '{default: '0};
      hold_q      <= '{default: '0};
      key_state   <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_long    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      key_state   <= state_d;
      key_press   <= press_d;
      key_release <= release_d;
      key_long    <= long_d;
    end
  end

endmodule

// File: tb/tb_multi_key_debounce.sv
// Scoreboard bench for multi_key_debounce: a tick-window reference model predicts events,
// a negedge monitor compares them against the DUT pulses.
module tb_multi_key_debounce;

  localparam int NK = 2;
  localparam int TD = 4;
  localparam int SC = 3;
  localparam int LT = 5;
  localparam bit AL = 1'b1;
  localparam int MaxTicks = 8192;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] key_state, key_press, key_release, key_long;

  always #5 clk = ~clk;

  multi_key_debounce #(
    .NUM_KEYS     (NK),
    .TICK_DIV     (TD),
    .STABLE_CNT   (SC),
    .LONG_TICKS   (LT),
    .IN_ACTIVE_LOW(AL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  typedef struct {
    int            e;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [NK-1:0] lng;
    logic [NK-1:0] state;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  n_press[NK];
  int  n_rel[NK];
  int  n_long[NK];

  // Reference model state: edges since reset, pin history, tick samples, accepted levels.
  int            ec;
  logic [NK-1:0] kin_hist[$];
  int            tn;
  logic [NK-1:0] st;
  int            acc_tn[NK];
  bit            samp[NK][MaxTicks];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, wanted %0d..%0d (t=%0t)", name, act, lo, hi, $time);
  endtask

  function automatic void model_reset();
    ec = 0;
    tn = 0;
    st = '0;
    kin_hist.delete();
    exp_q.delete();
    for (int k = 0; k < NK; k++) acc_tn[k] = -1;
  endfunction

  // New level is accepted once the last SC tick samples since the previous acceptance
  // all disagree with the current level.
  function automatic bit window_disagrees(input int k);
    for (int j = 0; j < SC; j++) begin
      if (tn - j <= acc_tn[k] || tn - j < 0) return 1'b0;
      if (samp[k][tn-j] == st[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_edge();
    logic [NK-1:0] p, pr, rl, lg;
    ev_t ev;
    int e;
    e = ec;
    ec++;
    kin_hist.push_back(key_in);
    p  = (e >= 2) ? (AL ? ~kin_hist[e-2] : kin_hist[e-2]) : '0;
    pr = '0;
    rl = '0;
    lg = '0;
    if (e % TD == TD - 1 && tn < MaxTicks) begin
      for (int k = 0; k < NK; k++) begin
        samp[k][tn] = p[k];
        if (LT != 0 && st[k] && (tn - acc_tn[k] == LT)) lg[k] = 1'b1;
        if (window_disagrees(k)) begin
          st[k]     = p[k];
          acc_tn[k] = tn;
          pr[k]     = p[k];
          rl[k]     = ~p[k];
        end
      end
      tn++;
    end
    if (|{pr, rl, lg}) begin
      ev.e = e; ev.press = pr; ev.rel = rl; ev.lng = lg; ev.state = st;
      exp_q.push_back(ev);
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  // Monitor: pops one expectation whenever the DUT shows any pulse.
  initial begin
    ev_t ev;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < NK; k++) begin
          n_press[k] += int'(key_press[k]);
          n_rel[k]   += int'(key_release[k]);
          n_long[k]  += int'(key_long[k]);
        end
        if (|{key_press, key_release, key_long}) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", int'({key_press, key_release, key_long}), 0);
          end else begin
            ev = exp_q.pop_front();
            check("ev_edge", ec - 1, ev.e);
            check("ev_press", int'(key_press), int'(ev.press));
            check("ev_release", int'(key_release), int'(ev.rel));
            check("ev_long", int'(key_long), int'(ev.lng));
            check("ev_state", int'(key_state), int'(ev.state));
          end
        end else if (exp_q.size() > 0 && exp_q[0].e < ec - 1) begin
          ev = exp_q.pop_front();
          check("missing_event_edge", ec - 1, ev.e);
        end
      end
    end
  end

  task automatic sync_step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic void clear_counts();
    for (int k = 0; k < NK; k++) begin
      n_press[k] = 0;
      n_rel[k]   = 0;
      n_long[k]  = 0;
    end
  endfunction

  // Counts clock edges until the chosen pulse (0 press, 1 release, 2 long) shows on key k.
  task automatic wait_pulse(input int kind, input int k, input int budget, output int n);
    logic [NK-1:0] v;
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      @(negedge clk);
      v = (kind == 0) ? key_press : (kind == 1) ? key_release : key_long;
      if (v[k]) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    clear_counts();
    // Idle reset
    key_in = '1;
    rst_n  = 1'b0;
    sync_step(3);
    check("reset_state", int'(key_state), 0);
    check("reset_events", int'({key_press, key_release, key_long}), 0);
    rst_n = 1'b1;
    sync_step(200);
    check("idle_state", int'(key_state), 0);
    check("idle_no_press", n_press[0] + n_press[1], 0);

    // Clean press and release on key 0
    key_in[0] = 1'b0;
    wait_pulse(0, 0, 40, n);
    check_rng("press0_latency", n, 11, 15);
    check("press0_state", int'(key_state), 2'b01);
    @(negedge clk);
    check("press0_one_cycle", int'(key_press), 0);
    sync_step(1);
    key_in[0] = 1'b1;
    wait_pulse(1, 0, 40, n);
    check_rng("release0_latency", n, 11, 15);
    check("release0_state", int'(key_state), 0);

    // Bounce rejection
    sync_step(10);
    clear_counts();
    for (int i = 0; i < 20; i++) begin
      key_in[0] = ~key_in[0];
      sync_step(3);
    end
    key_in[0] = 1'b1;
    sync_step(30);
    check("bounce_state", int'(key_state), 0);
    check("bounce_events", n_press[0] + n_rel[0], 0);

    // Long press on key 1
    clear_counts();
    key_in[1] = 1'b0;
    wait_pulse(0, 1, 40, n);
    check_rng("press1_latency", n, 11, 15);
    wait_pulse(2, 1, 40, n);
    check("long1_delay", n, 20);
    sync_step(45);
    key_in[1] = 1'b1;
    wait_pulse(1, 1, 40, n);
    check_rng("release1_latency", n, 11, 15);
    sync_step(2);
    check("long1_count", n_long[1], 1);
    check("press1_count", n_press[1], 1);
    check("release1_count", n_rel[1], 1);
    check("release1_state", int'(key_state), 0);

    // Simultaneous keys
    sync_step(20);
    clear_counts();
    key_in = '0;
    wait_pulse(0, 0, 40, n);
    check("simul_press_vec", int'(key_press), 2'b11);
    sync_step(1);
    key_in[0] = 1'b1;
    wait_pulse(1, 0, 40, n);
    check("simul_release_vec", int'(key_release), 2'b01);
    check("simul_state_after_rel0", int'(key_state), 2'b10);
    sync_step(1);
    check("simul_press_count", n_press[0] + n_press[1], 2);
    key_in = '1;
    sync_step(40);

    // Reset while key 0 is held
    key_in[0] = 1'b0;
    wait_pulse(0, 0, 40, n);
    check_rng("press0b_latency", n, 11, 15);
    sync_step(2);
    rst_n = 1'b0;
    #1;
    check("rst_async_state", int'(key_state), 0);
    check("rst_async_events", int'({key_press, key_release, key_long}), 0);
    clear_counts();
    sync_step(3);
    rst_n = 1'b1;
    wait_pulse(0, 0, 40, n);
    check_rng("press0_after_reset", n, 11, 15);
    sync_step(2);
    check("no_release_on_reset", n_rel[0], 0);
    key_in = '1;
    sync_step(30);

    // Randomised toggling with occasional resets, all checked by the scoreboard
    for (int i = 0; i < 150; i++) begin
      int idx;
      idx = int'($urandom_range(NK - 1, 0));
      key_in[idx] = ~key_in[idx];
      sync_step(int'($urandom_range(30, 1)));
      if (i % 50 == 49) begin
        rst_n = 1'b0;
        sync_step(2);
        rst_n = 1'b1;
      end
    end
    key_in = '1;
    sync_step(60);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
